spike_train_decoder: RTL and testbench
======================================

# spike_train_decoder

Receive-side companion to the Izhikevich neuron core. It consumes the neuron's 8-bit signed membrane-potential sample stream and detects spikes with hysteresis thresholds. For each spike it measures the inter-spike interval (ISI) in accepted samples and flags bursts. Each spike produces an event record queued in a small FIFO behind a valid/ready handshake for downstream logging or readout.

## Interface
Parameters:
- THRESH_HI, 8'sd64: spike threshold; a sample >= THRESH_HI while armed is a spike.
- THRESH_LO, 8'sd0: re-arm threshold; a sample <= THRESH_LO while refractory re-arms detection. Must be < THRESH_HI.
- BURST_ISI, 16'd8: a non-first spike with ISI <= BURST_ISI is flagged as a burst.
- FIFO_DEPTH, 4: event FIFO depth (power of two, >= 2).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- vm_in, input, 8: signed membrane sample (two's complement).
- vm_valid, input, 1: vm_in is accepted on each rising edge where vm_valid = 1.
- spike_pulse, output, 1: one-cycle strobe per detected spike.
- spike_count, output, 16: total spikes since reset; wraps modulo 2^16.
- evt_valid, output, 1: FIFO non-empty; head record is presented.
- evt_ready, input, 1: consumer accepts the head record on an edge where evt_valid & evt_ready.
- evt_isi, output, 16: head record ISI.
- evt_first, output, 1: head record is the first spike since reset.
- evt_burst, output, 1: head record burst flag.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: number of queued records.
- overflow, output, 1: sticky flag; set when a record is dropped because the FIFO is full.
- clr_overflow, input, 1: clears overflow.

## Operation
- Detector FSM has two states, ARMED and REFRACTORY. Reset state is ARMED.
  - ARMED: accepted sample >= THRESH_HI (signed compare) registers a spike and moves to REFRACTORY.
  - REFRACTORY: accepted sample <= THRESH_LO moves to ARMED. There is no spike detection in this state.
  - Samples between the thresholds hold the state.
  - The FSM never changes state on an edge with vm_valid = 0.
- ISI counter (16 bits, saturating at 0xFFFF) increments on every accepted sample, including the spike sample itself. The recorded ISI is the counter value including the spike sample; after a spike the counter restarts at 0.
  - Result: the ISI counts accepted samples after the previous spike sample, up to and including the current one.
  - For the first spike, counting starts at reset.
  - Cycles with vm_valid = 0 are not counted.
- first_pending is set by reset and cleared by the first spike. Record fields:
  - evt_first = first_pending.
  - evt_burst = !first_pending && isi <= BURST_ISI.
- FIFO behaviour:
  - Each spike pushes a {isi, first, burst} record.
  - Empty FIFO: evt_isi, evt_first and evt_burst are driven to 0.
  - Full FIFO with a pop on the same edge: the push is accepted and the level is unchanged.
  - Full FIFO with no pop: the record is dropped and overflow is set. spike_count still increments and ISI tracking is unaffected.
- overflow: clr_overflow clears it. If a set and a clear occur on the same edge, the set wins.
- spike_count increments once per spike regardless of FIFO state.

## Timing
- Reset values: spike_pulse = 0, spike_count = 0, evt_valid = 0, evt_isi/evt_first/evt_burst = 0, fifo_level = 0, overflow = 0. Also FSM = ARMED, ISI counter = 0, first_pending = 1.
- Reset asserted mid-operation discards all queued records and in-progress ISI immediately (asynchronous). The first spike after release is reported with evt_first = 1.
- A spike sample accepted at edge N produces:
  - spike_pulse high for exactly the cycle after edge N.
  - spike_count updated at edge N.
  - the record written at edge N+1, with evt_valid = 1 and fifo_level updated after edge N+1.
- Latency from spike sample to evt_valid is 2 edges on an empty FIFO.
- The minimum spike spacing is 2 accepted samples (the hysteresis requires a re-arm sample), so at most one push occurs per edge.
- Pop: on an edge with evt_valid & evt_ready, the next record (or zeros) appears on the following cycle. evt_ready while evt_valid = 0 is ignored.
- Back-to-back pops are sustained at one record per cycle.

## Test plan
- Basic spikes (HI = 64, LO = 0): feed samples -90, -50, 70, 20, -10, -60, -60, 80 with vm_valid = 1.
  - Expect 2 spike_pulses and spike_count = 2.
  - Record 1: isi = 3, first = 1, burst = 0.
  - Record 2: isi = 5, first = 0, burst = 1.
- Hysteresis and gaps: feed 70, 50, 70, -1, 70 with vm_valid deasserted for 3 idle cycles between each pair.
  - Expect exactly 2 spikes.
  - Second record: isi = 4, burst = 1; idle cycles are not counted.
- Overflow: hold evt_ready = 0 and generate 5 spikes.
  - Expect fifo_level = 4, overflow = 1, spike_count = 5; the popped records are the first four in order.
  - Pulse clr_overflow: overflow = 0.
  - Full FIFO with push and pop on the same edge: level stays at 4 and overflow stays 0.
- Saturation: feed 70, then 70000 samples of -100, then 70. Expect second record isi = 0xFFFF, burst = 0.
- Reset mid-operation: with FSM in REFRACTORY and 2 records queued, pulse rst.
  - Expect all outputs at reset values immediately.
  - A following 70 sample yields isi = 1, first = 1.
- Handshake: with 3 queued records, hold evt_ready = 1. Expect 3 consecutive single-cycle pops, then evt_valid = 0 and the data outputs at 0.

Source files
------------

// File: rtl/spike_train_decoder.sv
// spike_train_decoder: hysteresis spike detector with ISI/burst tagging and an event FIFO
module spike_train_decoder #(
  parameter logic signed [7:0] THRESH_HI = 8'sd64,
  parameter logic signed [7:0] THRESH_LO = 8'sd0,
  parameter logic [15:0] BURST_ISI = 16'd8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] vm_in,
  input  logic vm_valid,
  output logic spike_pulse,
  output logic [15:0] spike_count,
  output logic evt_valid,
  input  logic evt_ready,
  output logic [15:0] evt_isi,
  output logic evt_first,
  output logic evt_burst,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic overflow,
  input  logic clr_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {ARMED, REFRACTORY} state_t;
  state_t state, state_next;
  logic spike;
  logic [15:0] isi_cnt, isi_inc;
  logic first_pending;
  logic pend_valid, pend_first, pend_burst;
  logic [15:0] pend_isi;
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic full, pop, push, drop;
  assign isi_inc = (isi_cnt == 16'hFFFF) ? isi_cnt : isi_cnt + 16'd1;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign evt_valid = fifo_level != '0;
  assign pop = evt_valid & evt_ready;
  assign push = pend_valid & (~full | pop);
  assign drop = pend_valid & full & ~pop;
  assign evt_isi = evt_valid ? mem[rd_ptr][17:2] : 16'd0;
  assign evt_first = evt_valid & mem[rd_ptr][1];
  assign evt_burst = evt_valid & mem[rd_ptr][0];
  // Detector next state: spike only while armed; only accepted samples move the FSM
  always_comb begin
    state_next = state;
    spike = 1'b0;
    if (vm_valid && state == ARMED && $signed(vm_in) >= THRESH_HI) begin
      spike = 1'b1;
      state_next = REFRACTORY;
    end else if (vm_valid && state == REFRACTORY && $signed(vm_in) <= THRESH_LO) begin
      state_next = ARMED;
    end
  end
  // Detector state, ISI tracking, spike stats and the one-cycle record staging register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARMED;
      isi_cnt <= '0;
      first_pending <= 1'b1;
      spike_count <= '0;
      spike_pulse <= 1'b0;
      pend_valid <= 1'b0;
      pend_isi <= '0;
      pend_first <= 1'b0;
      pend_burst <= 1'b0;
    end else begin
      state <= state_next;
      spike_pulse <= spike;
      pend_valid <= spike;
      if (vm_valid) isi_cnt <= spike ? 16'd0 : isi_inc;
      if (spike) begin
        spike_count <= spike_count + 16'd1;
        first_pending <= 1'b0;
        pend_isi <= isi_inc;
        pend_first <= first_pending;
        pend_burst <= ~first_pending && isi_inc <= BURST_ISI;
      end
    end
  end
  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end
  // Record storage; when full with a pop, the freed head slot is the write slot
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pend_isi, pend_first, pend_burst};
  end
endmodule

// File: tb/tb_spike_train_decoder.sv
// tb_spike_train_decoder: directed self-checking bench for spike_train_decoder
module tb_spike_train_decoder;
  logic clk = 0;
  logic rst = 0;
  logic [7:0] vm_in = '0;
  logic vm_valid = 0;
  logic spike_pulse;
  logic [15:0] spike_count;
  logic evt_valid;
  logic evt_ready = 0;
  logic [15:0] evt_isi;
  logic evt_first, evt_burst;
  logic [2:0] fifo_level;
  logic overflow;
  logic clr_overflow = 0;
  int total = 0;
  int bad = 0;
  int pulses = 0;

  spike_train_decoder dut (
    .clk(clk), .rst(rst), .vm_in(vm_in), .vm_valid(vm_valid),
    .spike_pulse(spike_pulse), .spike_count(spike_count),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_isi(evt_isi),
    .evt_first(evt_first), .evt_burst(evt_burst), .fifo_level(fifo_level),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int v, input logic val);
    vm_in = 8'(v);
    vm_valid = val;
    @(posedge clk);
    #1;
    if (spike_pulse) pulses++;
  endtask

  task automatic head(input string tag, input int isi, input logic first, input logic burst);
    check({tag, "_valid"}, evt_valid, 1);
    check({tag, "_isi"}, evt_isi, isi);
    check({tag, "_first"}, evt_first, first);
    check({tag, "_burst"}, evt_burst, burst);
  endtask

  task automatic pop_one();
    evt_ready = 1;
    put(0, 0);
    evt_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    pulses = 0;
  endtask

  initial begin
    do_reset();
    check("rst_pulse", spike_pulse, 0);
    check("rst_count", spike_count, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_isi", evt_isi, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);

    // basic spikes
    put(-90, 1); put(-50, 1); put(70, 1);
    check("basic_pulse1", spike_pulse, 1);
    check("basic_cnt1", spike_count, 1);
    check("basic_lat1", evt_valid, 0);
    put(20, 1);
    check("basic_pulse_low", spike_pulse, 0);
    check("basic_lat2", evt_valid, 1);
    put(-10, 1); put(-60, 1); put(-60, 1); put(80, 1); put(0, 0);
    check("basic_pulses", pulses, 2);
    check("basic_cnt", spike_count, 2);
    check("basic_level", fifo_level, 2);
    head("basic_r1", 3, 1, 0);
    pop_one();
    head("basic_r2", 5, 0, 1);
    pop_one();
    check("basic_empty", evt_valid, 0);

    // hysteresis with idle gaps
    do_reset();
    put(70, 1); repeat (3) put(0, 0);
    put(50, 1); repeat (3) put(0, 0);
    put(70, 1); repeat (3) put(0, 0);
    put(-1, 1); repeat (3) put(0, 0);
    put(70, 1); put(0, 0);
    check("hyst_pulses", pulses, 2);
    check("hyst_level", fifo_level, 2);
    head("hyst_r1", 1, 1, 0);
    pop_one();
    head("hyst_r2", 4, 0, 1);

    // overflow
    do_reset();
    put(70, 1);
    for (int i = 0; i < 4; i++) begin put(-10, 1); put(70, 1); end
    put(0, 0); put(0, 0);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_count", spike_count, 5);
    clr_overflow = 1;
    put(0, 0);
    clr_overflow = 0;
    check("ovf_clr", overflow, 0);
    head("ovf_r1", 1, 1, 0);
    put(-10, 1); put(70, 1);
    evt_ready = 1;
    put(0, 0);
    evt_ready = 0;
    check("ovf_pp_level", fifo_level, 4);
    check("ovf_pp_flag", overflow, 0);
    check("ovf_pp_count", spike_count, 6);
    for (int i = 2; i <= 4; i++) begin
      head($sformatf("ovf_r%0d", i), 2, 0, 1);
      pop_one();
    end
    head("ovf_r6", 2, 0, 1);
    pop_one();
    check("ovf_empty", evt_valid, 0);

    // ISI saturation
    do_reset();
    put(70, 1);
    for (int i = 0; i < 70000; i++) put(-100, 1);
    put(70, 1); put(0, 0);
    head("sat_r1", 1, 1, 0);
    pop_one();
    head("sat_r2", 16'hFFFF, 0, 0);

    // asynchronous reset mid-operation
    do_reset();
    put(70, 1); put(-10, 1); put(70, 1); put(0, 0);
    check("mid_level", fifo_level, 2);
    #2 rst = 1;
    #1;
    check("mid_count", spike_count, 0);
    check("mid_valid", evt_valid, 0);
    check("mid_level0", fifo_level, 0);
    check("mid_isi", evt_isi, 0);
    check("mid_first", evt_first, 0);
    check("mid_pulse", spike_pulse, 0);
    check("mid_ovf", overflow, 0);
    rst = 0;
    put(70, 1); put(0, 0);
    head("mid_r1", 1, 1, 0);

    // back-to-back pops
    do_reset();
    put(70, 1); put(-10, 1); put(70, 1); put(-10, 1); put(70, 1); put(0, 0);
    check("hs_level", fifo_level, 3);
    head("hs_r1", 1, 1, 0);
    evt_ready = 1;
    put(0, 0);
    head("hs_r2", 2, 0, 1);
    check("hs_level2", fifo_level, 2);
    put(0, 0);
    head("hs_r3", 2, 0, 1);
    put(0, 0);
    evt_ready = 0;
    check("hs_valid", evt_valid, 0);
    check("hs_isi", evt_isi, 0);
    check("hs_first", evt_first, 0);
    check("hs_burst", evt_burst, 0);
    check("hs_level0", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
